// File: rtl/pixel_unstacker.sv
`default_nettype none
// ============================================================================
// Module   : pixel_unstacker
// Purpose  : Issues in-order 128-bit chunk read requests to a memory. Each
//            returned chunk is buffered in a small FIFO and then emitted as
//            eight 16-bit pixels over a valid/ready stream, together with
//            each pixel's linear frame address.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_unstacker #(
  parameter  int HRES   = 1280,
  parameter  int VRES   = 720,
  parameter  int DEPTH  = 4,
  localparam int NPIX   = HRES * VRES,
  localparam int NCHUNK = NPIX / 8,
  localparam int AW     = $clog2(NPIX),
  localparam int CAW    = $clog2(NCHUNK)
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           enable_in,
  output logic [CAW-1:0] req_addr_out,
  output logic           req_valid_out,
  input  logic           req_ready_in,
  input  logic [127:0]   rsp_data_in,
  input  logic           rsp_valid_in,
  output logic [15:0]    pix_data_out,
  output logic [AW-1:0]  pix_addr_out,
  output logic           pix_last_out,
  output logic           pix_valid_out,
  input  logic           pix_ready_in,
  output logic           overflow_out
);

  // Pointer width for the power-of-two FIFO, and counter width for 0..DEPTH.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0]  DEPTH_C      = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE_C        = CW'(1);
  localparam logic [CAW-1:0] LAST_CHUNK_C = CAW'(NCHUNK - 1);
  localparam logic [AW-1:0]  LAST_PIX_C   = AW'(NPIX - 1);

  logic [CW-1:0]  credits;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CAW-1:0] req_addr;
  logic [CAW-1:0] rd_chunk;
  logic [2:0]     idx;
  logic           overflow;
  logic [127:0]   mem [DEPTH];

  logic           req_fire;
  logic           pix_valid;
  logic           pix_fire;
  logic           pop;
  logic           full;
  logic           wr_en;
  logic           drop;
  logic [127:0]   head;

  // Request side: credits bound the chunks either in flight or buffered, so
  // the FIFO cannot overflow for well-behaved memories. Held low during reset.
  assign req_valid_out = rst_n_in && enable_in && (credits != '0);
  assign req_fire      = req_valid_out && req_ready_in;
  assign req_addr_out  = req_addr;

  // Pixel side.
  assign pix_valid = (count != '0);
  assign pix_fire  = pix_valid && pix_ready_in;
  assign pop       = pix_fire && (idx == 3'd7);
  assign full      = (count == DEPTH_C);

  // A response is stored only if a request is pending and there is room;
  // a pop in the same cycle frees the entry being written into.
  assign wr_en = rsp_valid_in && (outstanding != '0) && (!full || pop);
  assign drop  = rsp_valid_in && !wr_en;

  assign head          = mem[rd_ptr];
  assign pix_valid_out = pix_valid;
  assign pix_data_out  = pix_valid ? head[{idx, 4'b0000} +: 16] : 16'h0000;
  assign pix_addr_out  = {rd_chunk, idx};
  assign pix_last_out  = pix_valid && ({rd_chunk, idx} == LAST_PIX_C);
  assign overflow_out  = overflow;

  // Chunk storage; contents are only observed through a non-zero count.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_ptr] <= rsp_data_in;
    end
  end

  // Request address, credit and in-flight bookkeeping.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_addr    <= '0;
      credits     <= DEPTH_C;
      outstanding <= '0;
    end else begin
      if (req_fire) begin
        req_addr <= (req_addr == LAST_CHUNK_C) ? '0 : req_addr + CAW'(1);
      end
      case ({req_fire, pop})
        2'b10:   credits <= credits - ONE_C;
        2'b01:   credits <= credits + ONE_C;
        default: credits <= credits;
      endcase
      case ({req_fire, rsp_valid_in && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + ONE_C;
        2'b01:   outstanding <= outstanding - ONE_C;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Pixel index within the head chunk and frame-relative chunk number.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx      <= 3'd0;
      rd_chunk <= '0;
    end else if (pix_fire) begin
      idx <= idx + 3'd1;
      if (pop) begin
        rd_chunk <= (rd_chunk == LAST_CHUNK_C) ? '0 : rd_chunk + CAW'(1);
      end
    end
  end

endmodule
`default_nettype wire
